// File: rtl/tft_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tft_spi_sequencer
//   CPU-side sequencer for the ILI9341 TFT byte-level SPI engine. The CPU
//   pushes {D/C, byte} entries into a small command FIFO. A solid-fill unit
//   can stream N RGB565 pixels without CPU involvement. A four-state FSM
//   launches one byte at a time into the SPI engine and tracks its busy flag.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   io_wr      one-cycle write strobe for this register window
//   io_rd      one-cycle read strobe for this register window
//   io_addr    register select (0 FIFO/status, 1 colour, 2 count, 3 level)
//   io_wdata   write data
//   io_rdata   registered read data, valid the cycle after io_rd
//   spi_start  one-cycle launch pulse to the SPI engine
//   spi_dc     D/C level for the launched byte
//   spi_byte   byte for the SPI engine, held from launch to completion
//   spi_busy   SPI engine busy flag
//   irq_done   high when FIFO empty, no fill active and FSM idle
// ---------------------------------------------------------------------------
module tft_spi_sequencer #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [1:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic        spi_start,
    output logic        spi_dc,
    output logic [7:0]  spi_byte,
    input  logic        spi_busy,
    output logic        irq_done
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [8:0]         fifo_mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               fill_active_q, fill_active_d;
    logic               fill_pending_q, fill_pending_d;
    logic               fill_phase_q, fill_phase_d;      // 0 = HI byte next, 1 = LO byte next
    logic [15:0]        fill_color_q, fill_color_d;
    logic [15:0]        fill_count_q, fill_count_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [3:0]         tmo_q, tmo_d;
    logic               dc_q, dc_d;
    logic [7:0]         byte_q, byte_d;
    logic [15:0]        rdata_q, rdata_d;

    logic [FIFO_AW:0]   level;
    logic               fifo_empty;
    logic               fifo_full;
    logic [8:0]         fifo_head;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               ovf_set;
    logic               status_rd;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
    assign push_req   = io_wr && (io_addr == 2'd0);
    assign status_rd  = io_rd && (io_addr == 2'd0);

    // Launch pulse decoded from the state register so reset drops it at once.
    assign spi_start = (state_q == S_ISSUE);
    assign spi_dc    = dc_q;
    assign spi_byte  = byte_q;
    assign io_rdata  = rdata_q;
    assign irq_done  = fifo_empty && !fill_active_q && (state_q == S_IDLE);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fill_active_d  = fill_active_q;
        fill_pending_d = fill_pending_q;
        fill_phase_d   = fill_phase_q;
        fill_color_d   = fill_color_q;
        fill_count_d   = fill_count_q;
        remaining_d    = remaining_q;
        tmo_d          = tmo_q;
        dc_d           = dc_q;
        byte_d         = byte_q;
        rdata_d        = rdata_q;
        pop            = 1'b0;
        ovf_set        = 1'b0;
        push_ok        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !fill_active_q) begin
                    if (!spi_busy) begin
                        pop     = 1'b1;
                        dc_d    = fifo_head[8];
                        byte_d  = fifo_head[7:0];
                        state_d = S_ISSUE;
                    end
                end else if (fill_active_q) begin
                    if (!spi_busy) begin
                        dc_d         = 1'b1;
                        byte_d       = fill_phase_q ? fill_color_q[7:0] : fill_color_q[15:8];
                        fill_phase_d = !fill_phase_q;
                        // A pixel is complete once its LO byte is accepted.
                        if (fill_phase_q) begin
                            remaining_d = remaining_q - 16'd1;
                            if (remaining_q == 16'd1) begin
                                fill_active_d = 1'b0;
                            end
                        end
                        state_d = S_ISSUE;
                    end
                end else if (fill_pending_q && fifo_empty) begin
                    // Arm the fill only; the first byte goes out on the next IDLE visit.
                    fill_active_d  = 1'b1;
                    fill_pending_d = 1'b0;
                    fill_phase_d   = 1'b0;
                    remaining_d    = fill_count_q;
                end
            end
            S_ISSUE: begin
                tmo_d   = 4'd0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (spi_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == 4'd14) begin
                    // Fifteenth cycle without an acknowledge: give the byte up.
                    ovf_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!spi_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop in the same cycle frees the slot for a push into a full FIFO.
        if (push_req) begin
            if (!fifo_full || pop) begin
                push_ok  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (io_wr && (io_addr == 2'd1) && !fill_active_q) begin
            fill_color_d = io_wdata;
        end
        if (io_wr && (io_addr == 2'd2) && !fill_pending_q && !fill_active_q &&
            (io_wdata != 16'd0)) begin
            fill_count_d   = io_wdata;
            fill_pending_d = 1'b1;
        end

        // Read data always reflects the state before this cycle's writes.
        if (io_rd) begin
            case (io_addr)
                2'd0:    rdata_d = {11'b0, ovf_q, fill_active_q, fifo_full, fifo_empty, irq_done};
                2'd1:    rdata_d = fill_color_q;
                2'd2:    rdata_d = remaining_q;
                default: rdata_d = 16'(level);
            endcase
        end
    end

    // Overflow or timeout in the same cycle as a status read keeps ovf set.
    assign ovf_d = ovf_set ? 1'b1 : (status_rd ? 1'b0 : ovf_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ovf_q          <= 1'b0;
            fill_active_q  <= 1'b0;
            fill_pending_q <= 1'b0;
            fill_phase_q   <= 1'b0;
            fill_color_q   <= 16'd0;
            fill_count_q   <= 16'd0;
            remaining_q    <= 16'd0;
            tmo_q          <= 4'd0;
            dc_q           <= 1'b0;
            byte_q         <= 8'd0;
            rdata_q        <= 16'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ovf_q          <= ovf_d;
            fill_active_q  <= fill_active_d;
            fill_pending_q <= fill_pending_d;
            fill_phase_q   <= fill_phase_d;
            fill_color_q   <= fill_color_d;
            fill_count_q   <= fill_count_d;
            remaining_q    <= remaining_d;
            tmo_q          <= tmo_d;
            dc_q           <= dc_d;
            byte_q         <= byte_d;
            rdata_q        <= rdata_d;
        end
    end

    // Storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= io_wdata[8:0];
        end
    end

endmodule
